// File: rtl/digit_display_decoder_pkg.sv
// digit_disp_pkg: shared state encoding and seven-segment patterns for the digit display path.
package digit_disp_pkg;
  typedef enum logic [1:0] {IDLE, SHOW, ERROR} state_e;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E = 7'b0000110;
  // active-low {g,f,e,d,c,b,a}, indexed by digit
  localparam logic [6:0] SEG_DIGITS [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
endpackage

// File: rtl/digit_display_decoder_seven_seg_decode.sv
// seven_seg_decode: 4-bit code to active-low segment pattern; out-of-range codes show E.
module seven_seg_decode
  import digit_disp_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);
  assign seg_o = (code_i > 4'd9) ? SEG_E : SEG_DIGITS[code_i];
endmodule

// File: rtl/digit_display_decoder.sv
// digit_display_decoder: registered digit to one-hot LED / seven-segment driver with hold timeout and error blink.
module digit_display_decoder
  import digit_disp_pkg::*;
#(
  parameter int HOLD_CYCLES = 250_000_000,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] D_in,
  input  logic       d_valid,
  output logic [9:0] LED_out,
  output logic [6:0] HEX_out,
  output logic       digit_err
);
  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  state_e state_q, state_d;
  logic [3:0] digit_q, digit_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic blink_on_q, blink_on_d;
  logic [9:0] led_q, led_d;
  logic [6:0] hex_q, hex_d;
  logic err_q;
  logic [3:0] seg_code;
  logic [6:0] seg_pat;
  logic timeout, blink_wrap;
  assign timeout = (HOLD_CYCLES != 0) && (hold_cnt_q == HW'(HOLD_CYCLES - 1));
  assign blink_wrap = blink_cnt_q == BW'(BLINK_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    hold_cnt_d = hold_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d = blink_on_q;
    if (d_valid && D_in <= 4'd9) begin
      state_d = SHOW;
      digit_d = D_in;
      hold_cnt_d = '0;
    end else if (d_valid) begin
      state_d = ERROR;
      hold_cnt_d = '0;
      blink_cnt_d = '0;
      blink_on_d = 1'b1;
    end else if (state_q == SHOW && timeout) begin
      state_d = IDLE;
      hold_cnt_d = '0;
    end else if (state_q == SHOW) begin
      hold_cnt_d = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + HW'(1);
    end else if (state_q == ERROR) begin
      blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + BW'(1);
      blink_on_d = blink_wrap ? ~blink_on_q : blink_on_q;
    end
  end
  // outputs are decoded from next state so they update on the sampling edge
  assign seg_code = (state_d == ERROR) ? 4'hE : digit_d;
  seven_seg_decode u_seg (.code_i(seg_code), .seg_o(seg_pat));
  always_comb begin
    led_d = (state_d == SHOW) ? 10'(1) << digit_d :
            (state_d == ERROR && blink_on_d) ? 10'h3FF : 10'h000;
    hex_d = (state_d == SHOW || (state_d == ERROR && blink_on_d)) ? seg_pat : SEG_BLANK;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      digit_q <= '0;
      hold_cnt_q <= '0;
      blink_cnt_q <= '0;
      blink_on_q <= 1'b1;
      led_q <= 10'h000;
      hex_q <= SEG_BLANK;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      hold_cnt_q <= hold_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q <= blink_on_d;
      led_q <= led_d;
      hex_q <= hex_d;
      err_q <= state_d == ERROR;
    end
  end
  assign LED_out = led_q;
  assign HEX_out = hex_q;
  assign digit_err = err_q;
endmodule
